cpu_controller: RTL and testbench
=================================

// Module: cpu_controller
// PURPOSE
//   Instruction sequencer for the 8-bit CPU: the driving end of the 3-bit opcode/ALU interface.
//   Fetches two instruction bytes from ROM into the IR, then issues the memory, bus and
//   register strobes that bring operands to the ALU and commit its result.
//   Sits between the IR (which supplies i_op_code) and the PC, ROM/RAM, accumulator, R register and bus driver.
// PARAMETERS
//   CNT_W  16  width of retired-instruction counter o_instr_cnt
// PORTS
//   i_clk          in   1      system clock; one clock domain; all state changes on its rising edge
//   i_rst_n        in   1      reset; synchronous and active-low
//   i_ena          in   1      run enable; low parks the sequencer in IDLE at an instruction boundary
//   i_op_code      in   3      IR opcode: NOP=000 LDO=001 LDA=010 STO=011 PRE=100 ADD=101 LDM=110 HLT=111
//   o_load_ir      out  1      IR captures bus byte (FETCH1 high byte, FETCH2 low byte)
//   o_inc_pc       out  1      PC += 1 at end of cycle
//   o_rd           out  1      memory read strobe
//   o_wr           out  1      RAM write strobe
//   o_rom_sel      out  1      ROM chip select
//   o_ram_sel      out  1      RAM chip select
//   o_datactl_ena  out  1      drive accumulator onto data bus
//   o_load_acc     out  1      accumulator loads ALU output
//   o_load_reg     out  1      R register loads (bus for PRE, ALU output for LDM)
//   o_halt         out  1      high while in HALT
//   o_instr_cnt    out  CNT_W  instructions retired since reset
// BEHAVIOUR
//   - States (3-bit, registered): IDLE, FETCH1, FETCH2, DECODE, EXEC1, EXEC2, EXEC3, HALT.
//   - Reset (i_rst_n=0 at edge): state=IDLE, o_instr_cnt=0. All strobes are 0 in IDLE.
//     Reset wins over every other input and aborts any instruction in flight.
//   - Strobes are decoded combinationally from registered state and i_op_code.
//     i_op_code is stable from DECODE to EXEC3.
//   - IDLE: i_ena=1 -> FETCH1; otherwise stay in IDLE.
//   - Sequence: FETCH1->FETCH2->DECODE->EXEC1->EXEC2->EXEC3, then FETCH1 if i_ena=1, else IDLE.
//     Fixed 6 cycles per instruction.
//   - i_ena is sampled only in IDLE and EXEC3; deassertion mid-instruction lets the instruction complete.
//   - FETCH1, FETCH2: o_rd=o_rom_sel=o_load_ir=o_inc_pc=1.
//   - DECODE: all strobes 0. If opcode=HLT, next state=HALT (the instruction does not execute).
//   - EXEC1:
//       LDO/PRE: o_rd, o_rom_sel
//       LDA/ADD: o_rd, o_ram_sel
//       STO: o_ram_sel, o_datactl_ena
//       NOP/LDM: none
//   - EXEC2:
//       LDO/LDA/ADD: EXEC1 strobes held + o_load_acc
//       PRE: EXEC1 strobes held + o_load_reg
//       STO: o_ram_sel, o_datactl_ena, o_wr
//       LDM: o_load_reg
//       NOP: none
//   - EXEC3:
//       STO: o_ram_sel, o_datactl_ena (hold; o_wr=0)
//       all others: none
//   - Strobe rules: o_wr and o_rd are never both 1. o_load_acc and o_load_reg are each high
//     for at most one cycle per instruction.
//   - o_instr_cnt: +1 on the EXEC3 exit edge; wraps modulo 2^CNT_W. HLT is not counted.
//   - HALT: o_halt=1, all other strobes 0. Stays in HALT regardless of i_ena; exits only via reset.
//   - Opcode encodings are fixed; no illegal opcodes exist, so no default trap is needed.
// TESTING
//   1. Reset with i_ena=1 -> all outputs 0 and state IDLE; after release, FETCH1 strobes appear
//      on the next cycle.
//   2. ADD (101) with i_ena held high -> load_ir/inc_pc in cycles 1-2; rd+ram_sel in cycles 4-5;
//      load_acc only in cycle 5; FETCH1 in cycle 7; o_instr_cnt=1.
//   3. STO (011) -> datactl_ena in cycles 4-6; wr only in cycle 5; rd=0 throughout the execute
//      cycles.
//   4. Program NOP, PRE, LDM, HLT -> load_reg exactly once in each of PRE and LDM;
//      o_halt=1 from cycle 22; o_instr_cnt=3; i_ena toggling leaves HALT unchanged.
//   5. i_ena dropped during EXEC1 of LDA -> load_acc still fires in EXEC2; IDLE after EXEC3;
//      re-raising i_ena -> FETCH1 next cycle.
//   6. i_rst_n pulsed low during EXEC2 of STO -> o_wr=0 and state IDLE from the next edge;
//      o_instr_cnt=0. With CNT_W=2, 5 NOPs -> o_instr_cnt=1 (wrap-around).

Source files
------------

// File: rtl/cpu_controller_if.sv
// rtl/cpu_controller_if.sv - opcode/strobe bundle between the sequencer and the datapath
//   op_code      : IR opcode presented to the sequencer
//   load_ir      : IR captures bus byte
//   inc_pc       : PC increment
//   rd, wr       : memory read / RAM write strobes
//   rom_sel      : ROM chip select
//   ram_sel      : RAM chip select
//   datactl_ena  : accumulator drives the data bus
//   load_acc     : accumulator loads ALU output
//   load_reg     : R register load
interface cpu_controller_if;
    logic [2:0] op_code;
    logic       load_ir;
    logic       inc_pc;
    logic       rd;
    logic       wr;
    logic       rom_sel;
    logic       ram_sel;
    logic       datactl_ena;
    logic       load_acc;
    logic       load_reg;

    modport master (
        input  op_code,
        output load_ir, inc_pc, rd, wr, rom_sel, ram_sel, datactl_ena, load_acc, load_reg
    );

    modport slave (
        output op_code,
        input  load_ir, inc_pc, rd, wr, rom_sel, ram_sel, datactl_ena, load_acc, load_reg
    );
endinterface

// File: rtl/cpu_controller.sv
// rtl/cpu_controller.sv - 8-bit CPU instruction sequencer (fetch, decode, 3-cycle execute)
//   i_clk       : system clock
//   i_rst_n     : synchronous active-low reset
//   i_ena       : run enable, sampled only in IDLE and EXEC3
//   bus         : opcode in, memory/bus/register strobes out
//   o_halt      : high while in HALT
//   o_instr_cnt : instructions retired since reset (wraps)
module cpu_controller #(
    parameter int CNT_W = 16
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_ena,
    cpu_controller_if.master     bus,
    output logic                 o_halt,
    output logic [CNT_W-1:0]     o_instr_cnt
);
    typedef enum logic [2:0] {
        S_IDLE, S_FETCH1, S_FETCH2, S_DECODE, S_EXEC1, S_EXEC2, S_EXEC3, S_HALT
    } state_t;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDO = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STO = 3'b011;
    localparam logic [2:0] OP_PRE = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;
    localparam logic [2:0] OP_LDM = 3'b110;
    localparam logic [2:0] OP_HLT = 3'b111;

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_instr_cnt;

    logic w_load_ir, w_inc_pc, w_rd, w_wr, w_rom_sel, w_ram_sel;
    logic w_datactl_ena, w_load_acc, w_load_reg, w_halt;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_state     <= S_IDLE;
            r_instr_cnt <= '0;
        end else begin
            r_state <= w_next;
            if (r_state == S_EXEC3) begin
                r_instr_cnt <= r_instr_cnt + 1'b1;
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   w_next = i_ena ? S_FETCH1 : S_IDLE;
            S_FETCH1: w_next = S_FETCH2;
            S_FETCH2: w_next = S_DECODE;
            // HLT never enters the execute phase, so it is not counted as retired.
            S_DECODE: w_next = (bus.op_code == OP_HLT) ? S_HALT : S_EXEC1;
            S_EXEC1:  w_next = S_EXEC2;
            S_EXEC2:  w_next = S_EXEC3;
            S_EXEC3:  w_next = i_ena ? S_FETCH1 : S_IDLE;
            S_HALT:   w_next = S_HALT;
            default:  w_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_load_ir     = 1'b0;
        w_inc_pc      = 1'b0;
        w_rd          = 1'b0;
        w_wr          = 1'b0;
        w_rom_sel     = 1'b0;
        w_ram_sel     = 1'b0;
        w_datactl_ena = 1'b0;
        w_load_acc    = 1'b0;
        w_load_reg    = 1'b0;
        w_halt        = 1'b0;
        case (r_state)
            S_FETCH1, S_FETCH2: begin
                w_load_ir = 1'b1;
                w_inc_pc  = 1'b1;
                w_rd      = 1'b1;
                w_rom_sel = 1'b1;
            end
            // EXEC2 keeps the EXEC1 memory access alive so the operand is still
            // on the bus when the destination register loads.
            S_EXEC1, S_EXEC2: begin
                case (bus.op_code)
                    OP_LDO, OP_PRE: begin
                        w_rd      = 1'b1;
                        w_rom_sel = 1'b1;
                    end
                    OP_LDA, OP_ADD: begin
                        w_rd      = 1'b1;
                        w_ram_sel = 1'b1;
                    end
                    OP_STO: begin
                        w_ram_sel     = 1'b1;
                        w_datactl_ena = 1'b1;
                        w_wr          = (r_state == S_EXEC2);
                    end
                    default: ;
                endcase
                if (r_state == S_EXEC2) begin
                    w_load_acc = (bus.op_code == OP_LDO) || (bus.op_code == OP_LDA) ||
                                 (bus.op_code == OP_ADD);
                    w_load_reg = (bus.op_code == OP_PRE) || (bus.op_code == OP_LDM);
                end
            end
            // STO holds the bus one more cycle after wr drops so data outlives the write.
            S_EXEC3: begin
                if (bus.op_code == OP_STO) begin
                    w_ram_sel     = 1'b1;
                    w_datactl_ena = 1'b1;
                end
            end
            S_HALT:  w_halt = 1'b1;
            default: ;
        endcase
    end

    assign bus.load_ir     = w_load_ir;
    assign bus.inc_pc      = w_inc_pc;
    assign bus.rd          = w_rd;
    assign bus.wr          = w_wr;
    assign bus.rom_sel     = w_rom_sel;
    assign bus.ram_sel     = w_ram_sel;
    assign bus.datactl_ena = w_datactl_ena;
    assign bus.load_acc    = w_load_acc;
    assign bus.load_reg    = w_load_reg;
    assign o_halt          = w_halt;
    assign o_instr_cnt     = r_instr_cnt;
endmodule

// File: tb/tb_cpu_controller.sv
// tb/tb_cpu_controller.sv - self-checking bench for cpu_controller
module tb_cpu_controller;
    localparam logic [2:0] NOP = 3'b000, LDO = 3'b001, LDA = 3'b010, STO = 3'b011;
    localparam logic [2:0] PRE = 3'b100, ADD = 3'b101, LDM = 3'b110, HLT = 3'b111;

    // Strobe word layout: {load_ir, inc_pc, rd, wr, rom_sel, ram_sel, datactl_ena, load_acc, load_reg, halt}
    localparam int B_IR = 9, B_PC = 8, B_RD = 7, B_WR = 6, B_ROM = 5, B_RAM = 4;
    localparam int B_DC = 3, B_ACC = 2, B_REG = 1, B_HLT = 0;

    logic clk = 1'b0;
    logic rst_n;
    logic ena;
    logic rst2_n;
    logic ena2;
    logic        halt, halt2;
    logic [15:0] cnt;
    logic [1:0]  cnt2;

    int n_vec  = 0;
    int n_fail = 0;
    int model_cnt = 0;

    cpu_controller_if bus ();
    cpu_controller_if bus2 ();

    cpu_controller #(.CNT_W(16)) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_ena(ena), .bus(bus.master),
        .o_halt(halt), .o_instr_cnt(cnt)
    );

    cpu_controller #(.CNT_W(2)) u_dut2 (
        .i_clk(clk), .i_rst_n(rst2_n), .i_ena(ena2), .bus(bus2.master),
        .o_halt(halt2), .o_instr_cnt(cnt2)
    );

    always #5 clk = ~clk;

    function automatic logic [9:0] observed();
        return {bus.load_ir, bus.inc_pc, bus.rd, bus.wr, bus.rom_sel, bus.ram_sel,
                bus.datactl_ena, bus.load_acc, bus.load_reg, halt};
    endfunction

    // Expected strobes for cycle index p (0..5) of an instruction, from the opcode table.
    function automatic logic [9:0] expected(input int p, input logic [2:0] op);
        logic [9:0] e;
        e = '0;
        if (p <= 1) begin
            e[B_IR] = 1; e[B_PC] = 1; e[B_RD] = 1; e[B_ROM] = 1;
        end else if (p == 3 || p == 4) begin
            if (op == LDO || op == PRE) begin e[B_RD] = 1; e[B_ROM] = 1; end
            if (op == LDA || op == ADD) begin e[B_RD] = 1; e[B_RAM] = 1; end
            if (op == STO) begin e[B_RAM] = 1; e[B_DC] = 1; end
            if (p == 4) begin
                if (op == LDO || op == LDA || op == ADD) e[B_ACC] = 1;
                if (op == PRE || op == LDM) e[B_REG] = 1;
                if (op == STO) e[B_WR] = 1;
            end
        end else if (p == 5) begin
            if (op == STO) begin e[B_RAM] = 1; e[B_DC] = 1; end
        end
        return e;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Entered with the DUT in FETCH1; leaves it in FETCH1 of the next instruction.
    task automatic run_instr(input logic [2:0] op, input bit drop);
        bus.op_code = op;
        for (int p = 0; p < 6; p++) begin
            chk($sformatf("strobe op%0d c%0d", op, p), {22'd0, observed()}, {22'd0, expected(p, op)});
            if (drop && p == 3) ena = 1'b0;
            step();
        end
        model_cnt++;
        chk("instr_cnt", {16'd0, cnt}, model_cnt % 65536);
        if (drop) begin
            chk("idle after drop", {22'd0, observed()}, 32'd0);
            step();
            chk("idle parked", {22'd0, observed()}, 32'd0);
            ena = 1'b1;
            step();
        end
    endtask

    initial begin
        logic [2:0] rop;
        bit         rdrop;
        rst_n = 1'b0; ena = 1'b1; bus.op_code = NOP;
        rst2_n = 1'b0; ena2 = 1'b1; bus2.op_code = NOP;
        step();
        step();
        chk("reset strobes", {22'd0, observed()}, 32'd0);
        chk("reset cnt", {16'd0, cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        run_instr(ADD, 1'b0);
        run_instr(STO, 1'b0);
        run_instr(LDA, 1'b1);

        for (int i = 0; i < 40; i++) begin
            rop   = 3'($urandom_range(0, 6));
            rdrop = ($urandom_range(0, 3) == 0);
            run_instr(rop, rdrop);
        end

        bus.op_code = STO;
        for (int p = 0; p < 5; p++) begin
            chk($sformatf("sto pre-reset c%0d", p), {22'd0, observed()}, {22'd0, expected(p, STO)});
            if (p < 4) step();
        end
        rst_n = 1'b0;
        step();
        model_cnt = 0;
        chk("abort strobes", {22'd0, observed()}, 32'd0);
        chk("abort wr", {31'd0, bus.wr}, 32'd0);
        chk("abort cnt", {16'd0, cnt}, 32'd0);
        rst_n = 1'b1;
        step();

        run_instr(NOP, 1'b0);
        run_instr(PRE, 1'b0);
        run_instr(LDM, 1'b0);
        bus.op_code = HLT;
        for (int p = 0; p < 3; p++) begin
            chk($sformatf("hlt fetch c%0d", p), {22'd0, observed()}, {22'd0, expected(p, HLT)});
            step();
        end
        for (int i = 0; i < 6; i++) begin
            chk("halt strobes", {22'd0, observed()}, 32'd1);
            chk("halt cnt", {16'd0, cnt}, 32'd3);
            ena = ~ena;
            step();
        end

        chk("wrap reset cnt", {30'd0, cnt2}, 32'd0);
        rst2_n = 1'b1;
        step();
        repeat (30) step();
        chk("wrap cnt after 5 NOPs", {30'd0, cnt2}, 32'd1);
        chk("wrap fetch strobe", {31'd0, bus2.load_ir}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end
endmodule
